// File: rtl/accumulator_ctrl_pkg.sv
// rtl/accumulator_ctrl_pkg.sv - shared state, opcode and control-select encodings for the accumulator controller
package accumulator_ctrl_pkg;

  localparam int OP_W = 4;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_IMM_WB,
    S_ADDR,
    S_MEM_RD,
    S_MEM_WB,
    S_MEM_WR,
    S_BR,
    S_JMP,
    S_SP_DEC,
    S_PUSH_WR,
    S_POP_ADDR,
    S_POP_RD,
    S_POP_WB,
    S_HALT
  } state_e;

  localparam logic [OP_W-1:0] OP_LDA  = 4'h0;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h1;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h2;
  localparam logic [OP_W-1:0] OP_AND  = 4'h3;
  localparam logic [OP_W-1:0] OP_OR   = 4'h4;
  localparam logic [OP_W-1:0] OP_LD   = 4'h5;
  localparam logic [OP_W-1:0] OP_ST   = 4'h6;
  localparam logic [OP_W-1:0] OP_ADDI = 4'h7;
  localparam logic [OP_W-1:0] OP_BEQ  = 4'h8;
  localparam logic [OP_W-1:0] OP_BNE  = 4'h9;
  localparam logic [OP_W-1:0] OP_J    = 4'hA;
  localparam logic [OP_W-1:0] OP_PUSH = 4'hB;
  localparam logic [OP_W-1:0] OP_POP  = 4'hC;
  localparam logic [OP_W-1:0] OP_HALT = 4'hF;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_JUMP   = 2'd1;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd2;

  localparam logic [1:0] MADDR_PC     = 2'd0;
  localparam logic [1:0] MADDR_ALUOUT = 2'd1;
  localparam logic [1:0] MADDR_SELEFT = 2'd2;

  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_ACC = 2'd1;
  localparam logic [1:0] SRCA_SP  = 2'd2;

  localparam logic [2:0] SRCB_TWO = 3'd0;
  localparam logic [2:0] SRCB_MDR = 3'd1;
  localparam logic [2:0] SRCB_SE  = 3'd2;
  localparam logic [2:0] SRCB_ZE  = 3'd3;
  localparam logic [2:0] SRCB_SL1 = 3'd4;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_AND   = 3'd2;
  localparam logic [2:0] ALU_OR    = 3'd3;
  localparam logic [2:0] ALU_PASSA = 3'd4;
  localparam logic [2:0] ALU_PASSB = 3'd5;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       branch;
    logic       bne_or_beq;
    logic [1:0] pc_src;
    logic [1:0] mem_addr;
    logic       mem_write;
    logic       acc_write;
    logic       sp_write;
    logic [1:0] alu_src_a;
    logic [2:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       halted;
  } ctrl_t;

  function automatic logic is_illegal(input logic [OP_W-1:0] op);
    return (op == 4'hD) || (op == 4'hE);
  endfunction

endpackage

// File: rtl/accumulator_ctrl_decode.sv
// rtl/accumulator_ctrl_decode.sv - combinational state-to-control-word decoder
module accumulator_ctrl_decode
  import accumulator_ctrl_pkg::*;
(
  input  state_e          state_i,
  input  logic [OP_W-1:0] opcode_i,
  output ctrl_t           ctrl_o
);

  // Opcode only refines states already selected by it (ALU op, branch sense, illegal flag).
  always_comb begin
    ctrl_o = '0;
    unique case (state_i)
      S_FETCH: begin
        ctrl_o.mem_addr  = MADDR_PC;
        ctrl_o.ir_write  = 1'b1;
        ctrl_o.alu_src_a = SRCA_PC;
        ctrl_o.alu_src_b = SRCB_TWO;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_src    = PCSRC_ALU;
      end
      S_DECODE: begin
        ctrl_o.alu_src_a  = SRCA_PC;
        ctrl_o.alu_src_b  = SRCB_SL1;
        ctrl_o.alu_op     = ALU_ADD;
        ctrl_o.illegal    = is_illegal(opcode_i);
        ctrl_o.instr_done = is_illegal(opcode_i);
      end
      S_IMM_WB: begin
        ctrl_o.alu_src_a  = SRCA_ACC;
        ctrl_o.alu_src_b  = SRCB_SE;
        ctrl_o.alu_op     = (opcode_i == OP_ADDI) ? ALU_ADD : ALU_PASSB;
        ctrl_o.acc_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_ADDR: begin
        ctrl_o.alu_src_b = SRCB_ZE;
        ctrl_o.alu_op    = ALU_PASSB;
      end
      S_MEM_RD: begin
        ctrl_o.mem_addr = MADDR_ALUOUT;
      end
      S_MEM_WB: begin
        ctrl_o.alu_src_a  = SRCA_ACC;
        ctrl_o.alu_src_b  = SRCB_MDR;
        ctrl_o.acc_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
        case (opcode_i)
          OP_ADD:  ctrl_o.alu_op = ALU_ADD;
          OP_SUB:  ctrl_o.alu_op = ALU_SUB;
          OP_AND:  ctrl_o.alu_op = ALU_AND;
          OP_OR:   ctrl_o.alu_op = ALU_OR;
          default: ctrl_o.alu_op = ALU_PASSB;
        endcase
      end
      S_MEM_WR, S_PUSH_WR: begin
        ctrl_o.mem_addr   = MADDR_ALUOUT;
        ctrl_o.mem_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_BR: begin
        ctrl_o.alu_src_a  = SRCA_ACC;
        ctrl_o.alu_op     = ALU_PASSA;
        ctrl_o.branch     = 1'b1;
        ctrl_o.pc_src     = PCSRC_ALUOUT;
        ctrl_o.bne_or_beq = opcode_i[0];
        ctrl_o.instr_done = 1'b1;
      end
      S_JMP: begin
        ctrl_o.pc_write   = 1'b1;
        ctrl_o.pc_src     = PCSRC_JUMP;
        ctrl_o.instr_done = 1'b1;
      end
      S_SP_DEC: begin
        ctrl_o.alu_src_a = SRCA_SP;
        ctrl_o.alu_src_b = SRCB_TWO;
        ctrl_o.alu_op    = ALU_SUB;
        ctrl_o.sp_write  = 1'b1;
      end
      S_POP_ADDR: begin
        ctrl_o.alu_src_a = SRCA_SP;
        ctrl_o.alu_op    = ALU_PASSA;
      end
      S_POP_RD: begin
        ctrl_o.mem_addr  = MADDR_ALUOUT;
        ctrl_o.alu_src_a = SRCA_SP;
        ctrl_o.alu_src_b = SRCB_TWO;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.sp_write  = 1'b1;
      end
      S_POP_WB: begin
        ctrl_o.alu_src_b  = SRCB_MDR;
        ctrl_o.alu_op     = ALU_PASSB;
        ctrl_o.acc_write  = 1'b1;
        ctrl_o.instr_done = 1'b1;
      end
      S_HALT: begin
        ctrl_o.halted = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/accumulator_control.sv
// rtl/accumulator_control.sv - multicycle control FSM driving the accumulator datapath
module accumulator_control
  import accumulator_ctrl_pkg::*;
#(
  parameter int OPW     = 4,
  parameter int INSTR_W = 16
) (
  input  logic           CLK,
  input  logic           reset,
  input  logic [OPW-1:0] opcode,
  output logic           IRWrite,
  output logic           PCWrite,
  output logic           Branch,
  output logic           bneOrbeq,
  output logic [1:0]     PCSrc,
  output logic [1:0]     MemAddr,
  output logic           MemWrite,
  output logic           AccWrite,
  output logic           SpWrite,
  output logic [1:0]     ALUSrcA,
  output logic [2:0]     ALUSrcB,
  output logic [2:0]     ALUOp,
  output logic           instr_done,
  output logic           illegal,
  output logic           halted
);

  if ((OPW != OP_W) || (INSTR_W < OPW)) begin : g_bad_cfg
    $error("accumulator_control: unsupported OPW/INSTR_W combination");
  end

  state_e state_q, state_d;
  ctrl_t  dec_ctrl, ctrl;

  always_ff @(posedge CLK) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LDA, OP_ADDI:                     state_d = S_IMM_WB;
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_LD, OP_ST:                        state_d = S_ADDR;
          OP_BEQ, OP_BNE:                      state_d = S_BR;
          OP_J:                                state_d = S_JMP;
          OP_PUSH:                             state_d = S_SP_DEC;
          OP_POP:                              state_d = S_POP_ADDR;
          OP_HALT:                             state_d = S_HALT;
          default:                             state_d = S_FETCH;
        endcase
      end
      S_ADDR:     state_d = (opcode == OP_ST) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = S_MEM_WB;
      S_SP_DEC:   state_d = S_PUSH_WR;
      S_POP_ADDR: state_d = S_POP_RD;
      S_POP_RD:   state_d = S_POP_WB;
      S_HALT:     state_d = S_HALT;
      default:    state_d = S_FETCH;
    endcase
  end

  accumulator_ctrl_decode u_decode (
    .state_i  (state_q),
    .opcode_i (opcode),
    .ctrl_o   (dec_ctrl)
  );

  // Holding reset low silences the datapath immediately, before the state register catches up.
  assign ctrl = reset ? dec_ctrl : '0;

  assign IRWrite    = ctrl.ir_write;
  assign PCWrite    = ctrl.pc_write;
  assign Branch     = ctrl.branch;
  assign bneOrbeq   = ctrl.bne_or_beq;
  assign PCSrc      = ctrl.pc_src;
  assign MemAddr    = ctrl.mem_addr;
  assign MemWrite   = ctrl.mem_write;
  assign AccWrite   = ctrl.acc_write;
  assign SpWrite    = ctrl.sp_write;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign instr_done = ctrl.instr_done;
  assign illegal    = ctrl.illegal;
  assign halted     = ctrl.halted;

endmodule

// File: tb/tb_accumulator_control.sv
// tb/tb_accumulator_control.sv - directed and randomized bench for accumulator_control
module tb_accumulator_control;

  typedef struct packed {
    logic       irw, pcw, br, bne;
    logic [1:0] pcsrc, maddr;
    logic       mw, aw, sw;
    logic [1:0] srca;
    logic [2:0] srcb, aluop;
    logic       done, ill, halt;
  } cw_t;

  logic       CLK = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       IRWrite, PCWrite, Branch, bneOrbeq, MemWrite, AccWrite, SpWrite;
  logic       instr_done, illegal, halted;
  logic [1:0] PCSrc, MemAddr, ALUSrcA;
  logic [2:0] ALUSrcB, ALUOp;

  int checks = 0;
  int errors = 0;
  cw_t exp_q[$];

  accumulator_control #(.OPW(4), .INSTR_W(16)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .Branch(Branch), .bneOrbeq(bneOrbeq),
    .PCSrc(PCSrc), .MemAddr(MemAddr), .MemWrite(MemWrite), .AccWrite(AccWrite),
    .SpWrite(SpWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .instr_done(instr_done), .illegal(illegal), .halted(halted)
  );

  always #5 CLK = ~CLK;

  function automatic cw_t observed();
    return {IRWrite, PCWrite, Branch, bneOrbeq, PCSrc, MemAddr, MemWrite, AccWrite,
            SpWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, illegal, halted};
  endfunction

  task automatic check(input string tag, input cw_t e);
    cw_t o;
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Reference: the per-cycle control words an instruction must produce, fetch first.
  task automatic build(input logic [3:0] op);
    cw_t c;
    exp_q.delete();
    c = '0; c.irw = 1; c.pcw = 1;                        exp_q.push_back(c);
    c = '0; c.srcb = 4;
    if (op == 4'hD || op == 4'hE) begin c.ill = 1; c.done = 1; end
    exp_q.push_back(c);
    case (op)
      4'h0, 4'h7: begin
        c = '0; c.srca = 1; c.srcb = 2; c.aluop = (op == 4'h0) ? 3'd5 : 3'd0;
        c.aw = 1; c.done = 1;                            exp_q.push_back(c);
      end
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        c = '0; c.srcb = 3; c.aluop = 5;                 exp_q.push_back(c);
        c = '0; c.maddr = 1;                             exp_q.push_back(c);
        c = '0; c.srca = 1; c.srcb = 1; c.aw = 1; c.done = 1;
        case (op)
          4'h1: c.aluop = 0;
          4'h2: c.aluop = 1;
          4'h3: c.aluop = 2;
          4'h4: c.aluop = 3;
          default: c.aluop = 5;
        endcase
        exp_q.push_back(c);
      end
      4'h6: begin
        c = '0; c.srcb = 3; c.aluop = 5;                 exp_q.push_back(c);
        c = '0; c.maddr = 1; c.mw = 1; c.done = 1;       exp_q.push_back(c);
      end
      4'h8, 4'h9: begin
        c = '0; c.srca = 1; c.aluop = 4; c.br = 1; c.pcsrc = 2;
        c.bne = (op == 4'h9); c.done = 1;                exp_q.push_back(c);
      end
      4'hA: begin
        c = '0; c.pcw = 1; c.pcsrc = 1; c.done = 1;      exp_q.push_back(c);
      end
      4'hB: begin
        c = '0; c.srca = 2; c.aluop = 1; c.sw = 1;       exp_q.push_back(c);
        c = '0; c.maddr = 1; c.mw = 1; c.done = 1;       exp_q.push_back(c);
      end
      4'hC: begin
        c = '0; c.srca = 2; c.aluop = 4;                 exp_q.push_back(c);
        c = '0; c.maddr = 1; c.srca = 2; c.sw = 1;       exp_q.push_back(c);
        c = '0; c.srcb = 1; c.aluop = 5; c.aw = 1; c.done = 1; exp_q.push_back(c);
      end
      default: ;
    endcase
  endtask

  // Entered with the DUT in FETCH; leaves it in the state after the instruction's last step.
  task automatic run_instr(input logic [3:0] op, input string tag);
    opcode = op;
    build(op);
    #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      check($sformatf("%s[%0d]", tag, i), exp_q[i]);
      tick();
    end
  endtask

  initial begin
    cw_t z;
    cw_t halt_w;
    logic [3:0] op;
    z = '0;
    halt_w = '0;
    halt_w.halt = 1;

    reset = 1'b0;
    opcode = 4'h6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("reset_hold[%0d]", i), z);
    end
    reset = 1'b1;

    run_instr(4'h1, "add");
    run_instr(4'h9, "bne");
    run_instr(4'h8, "beq");
    run_instr(4'hB, "push");
    run_instr(4'hC, "pop");
    run_instr(4'hE, "illegal_e");
    run_instr(4'hD, "illegal_d");
    run_instr(4'h6, "st");

    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op, $sformatf("rand%0d_op%h", n, op));
    end

    // Reset lands in MEM_RD of ld: the write-back must never appear.
    opcode = 4'h5;
    build(4'h5);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ld_abort[%0d]", i), exp_q[i]);
      if (i < 3) tick();
    end
    reset = 1'b0;
    #1;
    check("ld_abort_gate", z);
    tick();
    check("ld_abort_after_edge", z);
    reset = 1'b1;
    run_instr(4'h0, "lda_after_abort");

    run_instr(4'hF, "halt_entry");
    for (int i = 0; i < 20; i++) begin
      check($sformatf("halt_hold[%0d]", i), halt_w);
      tick();
    end
    reset = 1'b0;
    #1;
    check("halt_reset_gate", z);
    tick();
    reset = 1'b1;
    run_instr(4'h7, "addi_after_halt");
    run_instr(4'hA, "j");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accumulator_control.md
Name: accumulator_control

Overview:
Multicycle control FSM directly upstream of the accumulator datapath top; it generates every control input that top consumes (PCWrite, Branch, bneOrbeq, PCSrc, MemAddr, MemWrite, AccWrite, SpWrite, ALUSrcA, ALUSrcB, ALUOp) plus IRWrite. It decodes the 4-bit opcode in IR[15:12] and sequences fetch, decode, address, memory, writeback and branch states. Outputs are Moore (decoded from the registered state only); the datapath's Zero resolves branches inside the PC block, not here.

Parameters:
OPW, 4, opcode width (IR[15:12])
INSTR_W, 16, instruction width; only the top OPW bits are inspected

Ports:
CLK  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (sampled on CLK rising edge; 0 = reset)
opcode  input  OPW  IR[15:12] from instruction register, valid from DECODE onward
IRWrite  output  1  load instruction register from memory output
PCWrite  output  1  unconditional PC load
Branch  output  1  conditional PC load (qualified by Zero in PC block)
bneOrbeq  output  1  0 = beq (take on Zero=1), 1 = bne (take on Zero=0)
PCSrc  output  2  0 = ALU result, 1 = jump target (SELeft), 2 = ALUOut
MemAddr  output  2  0 = PC, 1 = ALUOut, 2 = SELeft
MemWrite  output  1  write ACC to memory
AccWrite  output  1  load ACC from ALU result
SpWrite  output  1  load SP from ALU result
ALUSrcA  output  2  0 = PC, 1 = ACC, 2 = SP
ALUSrcB  output  3  0 = const 2, 1 = MDR, 2 = SE, 3 = ZE, 4 = SL1
ALUOp  output  3  0 add, 1 sub, 2 and, 3 or, 4 passA, 5 passB
instr_done  output  1  one-cycle pulse in an instruction's last state
illegal  output  1  one-cycle pulse when DECODE sees an undefined opcode
halted  output  1  high while in HALT

Behaviour:
- State register updates on CLK rising edge. reset==0 at an edge -> state = FETCH. While reset==0, all enables (IRWrite, PCWrite, Branch, MemWrite, AccWrite, SpWrite) and all pulses/flags are forced to 0; selects are forced to 0.
- Unlisted outputs are 0 in every state.
- FETCH: MemAddr=0, IRWrite=1, A=PC, B=const2, add, PCWrite=1, PCSrc=0 -> DECODE.
- DECODE: A=PC, B=SL1, add (branch target into ALUOut) -> dispatch on opcode.
- Opcodes: 0 lda imm, 1 add mem, 2 sub mem, 3 and mem, 4 or mem, 5 ld mem, 6 st mem, 7 addi imm, 8 beq, 9 bne, A j, B push, C pop, F halt; D/E illegal.
- lda: IMM_WB (A=ACC, B=SE, passB, AccWrite) -> FETCH. addi: IMM_WB with add.
- 1-6: ADDR (B=ZE, passB) -> MEM_RD (MemAddr=1) -> MEM_WB (A=ACC, B=MDR, op = add/sub/and/or, or passB for ld; AccWrite) -> FETCH. st: ADDR -> MEM_WR (MemAddr=1, MemWrite) -> FETCH.
- beq/bne: BR (A=ACC, passA, Branch=1, PCSrc=2, bneOrbeq=opcode[0]) -> FETCH.
- j: JMP (PCWrite, PCSrc=1) -> FETCH.
- push: SP_DEC (A=SP, B=const2, sub, SpWrite) -> PUSH_WR (MemAddr=1, MemWrite) -> FETCH.
- pop: POP_ADDR (A=SP, passA) -> POP_RD (MemAddr=1; A=SP, B=const2, add, SpWrite) -> POP_WB (B=MDR, passB, AccWrite) -> FETCH.
- halt: HALT, absorbing, halted=1, no enables; exit only by reset.
- Illegal opcode: DECODE asserts illegal, next state FETCH (acts as 2-cycle nop); instr_done also pulses.
- instr_done is high in the final state of every instruction (IMM_WB, MEM_WB, MEM_WR, BR, JMP, PUSH_WR, POP_WB, illegal DECODE).
- CPI: lda/addi/beq/bne/j 3; st/push 4; arith/ld 5; pop 5.
- Reset arriving mid-instruction aborts it; no partial write completes after the reset edge.

Decomposition:
- Package accumulator_ctrl_pkg: state enum, opcode constants, PCSrc/MemAddr/ALUSrcA/ALUSrcB/ALUOp encodings, shared with the datapath.
- One sub-module natural: accumulator_ctrl_decode, a pure combinational state -> control-word decoder; the top holds only the state register and next-state logic.

Test Plan:
- Hold reset=0 for 3 cycles with opcode=6 -> every enable 0; first cycle after release is FETCH (IRWrite=1, PCWrite=1, MemAddr=0).
- opcode=1 (add) -> FETCH, DECODE, ADDR, MEM_RD, MEM_WB; MEM_WB shows A=1, B=1, ALUOp=0, AccWrite=1, instr_done=1; then FETCH.
- opcode=9 (bne) -> BR cycle has Branch=1, PCSrc=2, bneOrbeq=1, PCWrite=0; 3-cycle instruction.
- opcode=B then C -> push: SpWrite with ALUOp=1, next cycle MemWrite=1 with MemAddr=1; pop: POP_RD SpWrite with ALUOp=0, POP_WB AccWrite with B=1.
- opcode=E -> illegal=1 and instr_done=1 in DECODE, next state FETCH; opcode=F -> halted=1 held for 20 cycles with no enables, cleared by reset=0.
- Assert reset=0 during MEM_RD of ld -> no AccWrite ever asserted for that instruction; FETCH follows release.
